// File: rtl/pixel_gain.sv
`default_nettype none
// ============================================================================
// Module   : pixel_gain
// Brief    : Per-channel fixed-point pixel gain with round-half-up, saturation,
//            frame-synchronous gain/bypass update and per-frame clip counter.
// Revision : 1.0
// ============================================================================
module pixel_gain #(
    parameter int CHANNEL_COUNT = 3,
    parameter int PIXEL_WIDTH   = 8,
    parameter int GAIN_WIDTH    = 16,
    parameter int GAIN_FRAC     = 10,
    parameter int SAT_CNT_WIDTH = 24
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [CHANNEL_COUNT*GAIN_WIDTH-1:0]  gain_i,
    input  logic                                 gain_wr_i,
    input  logic                                 bypass_i,
    input  logic [CHANNEL_COUNT*PIXEL_WIDTH-1:0] di_i,
    input  logic                                 de_i,
    input  logic                                 hs_i,
    input  logic                                 vs_i,
    output logic [CHANNEL_COUNT*PIXEL_WIDTH-1:0] do_o,
    output logic                                 de_o,
    output logic                                 hs_o,
    output logic                                 vs_o,
    output logic                                 sat_o,
    output logic [SAT_CNT_WIDTH-1:0]             sat_count_o
);

    localparam int c_pix_bus_w  = CHANNEL_COUNT * PIXEL_WIDTH;
    localparam int c_gain_bus_w = CHANNEL_COUNT * GAIN_WIDTH;
    localparam int c_prod_w     = PIXEL_WIDTH + GAIN_WIDTH;
    localparam int c_prod_bus_w = CHANNEL_COUNT * c_prod_w;
    localparam int c_res_w      = c_prod_w - GAIN_FRAC;
    localparam logic [GAIN_WIDTH-1:0] c_unity = GAIN_WIDTH'(1) << GAIN_FRAC;
    localparam logic [c_prod_w-1:0]   c_half  = c_prod_w'(1) << (GAIN_FRAC - 1);

    // Control registers
    logic [c_gain_bus_w-1:0]  pend_gain_q, pend_gain_d;
    logic                     pend_q, pend_d;
    logic [c_gain_bus_w-1:0]  act_gain_q, act_gain_d;
    logic                     act_byp_q, act_byp_d;

    // Pipeline registers; sync bundles are {vs, hs, de}
    logic [c_pix_bus_w-1:0]   s1_pix_q, s1_pix_d;
    logic [c_gain_bus_w-1:0]  s1_gain_q, s1_gain_d;
    logic                     s1_byp_q, s1_byp_d;
    logic [2:0]               s1_sync_q, s1_sync_d;
    logic [c_prod_bus_w-1:0]  s2_prod_q, s2_prod_d;
    logic [c_pix_bus_w-1:0]   s2_pix_q, s2_pix_d;
    logic                     s2_byp_q, s2_byp_d;
    logic [2:0]               s2_sync_q, s2_sync_d;
    logic [c_pix_bus_w-1:0]   do_q, do_d;
    logic [2:0]               sync_q, sync_d;
    logic                     sat_q, sat_d;

    // Saturation statistics
    logic                     vs_prev_q, vs_prev_d;
    logic [SAT_CNT_WIDTH-1:0] sat_cnt_q, sat_cnt_d;
    logic [SAT_CNT_WIDTH-1:0] sat_count_q, sat_count_d;

    logic [c_prod_bus_w-1:0]  w_prod;
    logic [c_pix_bus_w-1:0]   w_gained;
    logic [CHANNEL_COUNT-1:0] w_ch_sat;
    logic [SAT_CNT_WIDTH-1:0] w_cnt_inc;

    generate
        for (genvar n = 0; n < CHANNEL_COUNT; n++) begin : g_chan
            logic [c_res_w-1:0] w_res;

            assign w_prod[n*c_prod_w +: c_prod_w] =
                {{GAIN_WIDTH{1'b0}}, s1_pix_q[n*PIXEL_WIDTH +: PIXEL_WIDTH]} *
                {{PIXEL_WIDTH{1'b0}}, s1_gain_q[n*GAIN_WIDTH +: GAIN_WIDTH]};

            // Full-width product plus half LSB cannot wrap, so no guard bit is needed
            assign w_res = c_res_w'((s2_prod_q[n*c_prod_w +: c_prod_w] + c_half) >> GAIN_FRAC);
            assign w_ch_sat[n] = |w_res[c_res_w-1:PIXEL_WIDTH];
            assign w_gained[n*PIXEL_WIDTH +: PIXEL_WIDTH] =
                w_ch_sat[n] ? {PIXEL_WIDTH{1'b1}} : w_res[PIXEL_WIDTH-1:0];
        end
    endgenerate

    // A write always wins over an apply in the same cycle
    always_comb begin
        pend_gain_d = pend_gain_q;
        pend_d      = pend_q;
        act_gain_d  = act_gain_q;
        act_byp_d   = act_byp_q;
        if (gain_wr_i) begin
            pend_gain_d = gain_i;
            pend_d      = 1'b1;
        end else if (vs_i && pend_q) begin
            act_gain_d  = pend_gain_q;
            pend_d      = 1'b0;
        end
        if (vs_i) begin
            act_byp_d = bypass_i;
        end
    end

    always_comb begin
        s1_pix_d  = di_i;
        s1_sync_d = {vs_i, hs_i, de_i};
        s1_gain_d = act_gain_q;
        s1_byp_d  = act_byp_q;

        s2_prod_d = w_prod;
        s2_pix_d  = s1_pix_q;
        s2_sync_d = s1_sync_q;
        s2_byp_d  = s1_byp_q;

        do_d   = s2_byp_q ? s2_pix_q : w_gained;
        sync_d = s2_sync_q;
        sat_d  = s2_sync_q[0] && !s2_byp_q && (|w_ch_sat);
    end

    // Hit in the rising-edge cycle itself still belongs to the closing frame
    always_comb begin
        w_cnt_inc = sat_cnt_q;
        if (sync_q[0] && sat_q && (sat_cnt_q != {SAT_CNT_WIDTH{1'b1}})) begin
            w_cnt_inc = sat_cnt_q + SAT_CNT_WIDTH'(1);
        end
        vs_prev_d   = sync_q[2];
        sat_count_d = sat_count_q;
        sat_cnt_d   = w_cnt_inc;
        if (sync_q[2] && !vs_prev_q) begin
            sat_count_d = w_cnt_inc;
            sat_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_gain_q <= '0;
            pend_q      <= 1'b0;
            act_gain_q  <= {CHANNEL_COUNT{c_unity}};
            act_byp_q   <= 1'b0;
            s1_pix_q    <= '0;
            s1_gain_q   <= '0;
            s1_byp_q    <= 1'b0;
            s1_sync_q   <= '0;
            s2_prod_q   <= '0;
            s2_pix_q    <= '0;
            s2_byp_q    <= 1'b0;
            s2_sync_q   <= '0;
            do_q        <= '0;
            sync_q      <= '0;
            sat_q       <= 1'b0;
            vs_prev_q   <= 1'b0;
            sat_cnt_q   <= '0;
            sat_count_q <= '0;
        end else begin
            pend_gain_q <= pend_gain_d;
            pend_q      <= pend_d;
            act_gain_q  <= act_gain_d;
            act_byp_q   <= act_byp_d;
            s1_pix_q    <= s1_pix_d;
            s1_gain_q   <= s1_gain_d;
            s1_byp_q    <= s1_byp_d;
            s1_sync_q   <= s1_sync_d;
            s2_prod_q   <= s2_prod_d;
            s2_pix_q    <= s2_pix_d;
            s2_byp_q    <= s2_byp_d;
            s2_sync_q   <= s2_sync_d;
            do_q        <= do_d;
            sync_q      <= sync_d;
            sat_q       <= sat_d;
            vs_prev_q   <= vs_prev_d;
            sat_cnt_q   <= sat_cnt_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign do_o        = do_q;
    assign de_o        = sync_q[0];
    assign hs_o        = sync_q[1];
    assign vs_o        = sync_q[2];
    assign sat_o       = sat_q;
    assign sat_count_o = sat_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_gain.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_gain
// Brief    : Directed bench for pixel_gain with an arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_pixel_gain;

    localparam int CH = 3;
    localparam int PW = 8;
    localparam int GW = 16;
    localparam int GF = 10;
    localparam int SW = 24;

    logic             clk = 1'b0;
    logic             rst;
    logic [CH*GW-1:0] gain_i;
    logic             gain_wr_i;
    logic             bypass_i;
    logic [CH*PW-1:0] di_i;
    logic             de_i, hs_i, vs_i;
    logic [CH*PW-1:0] do_o;
    logic             de_o, hs_o, vs_o, sat_o;
    logic [SW-1:0]    sat_count_o;

    always #5 clk = ~clk;

    pixel_gain #(
        .CHANNEL_COUNT(CH), .PIXEL_WIDTH(PW), .GAIN_WIDTH(GW),
        .GAIN_FRAC(GF), .SAT_CNT_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst), .gain_i(gain_i), .gain_wr_i(gain_wr_i),
        .bypass_i(bypass_i), .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
        .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .sat_o(sat_o),
        .sat_count_o(sat_count_o)
    );

    typedef struct {
        logic [CH*PW-1:0] d;
        bit de, hs, vs, sat;
    } exp_t;

    // Reference state: one expected output per sampled input cycle
    exp_t   hist[$];
    longint m_act[CH];
    longint m_pend_g[CH];
    bit     m_pend, m_byp, m_rst_edge;
    exp_t   prev_e;
    longint m_cnt, m_count;
    bit     m_prev_vs;
    int     n_tests = 0;
    int     n_fail  = 0;

    function automatic exp_t zero_e();
        exp_t e;
        e.d = '0; e.de = 0; e.hs = 0; e.vs = 0; e.sat = 0;
        return e;
    endfunction

    function automatic exp_t model_pixel(logic [CH*PW-1:0] pix, bit de, bit hs, bit vs);
        exp_t   e;
        bit     any_sat = 0;
        longint v, r;
        e = zero_e();
        e.de = de; e.hs = hs; e.vs = vs;
        for (int ch = 0; ch < CH; ch++) begin
            v = longint'(pix[ch*PW +: PW]);
            if (m_byp) begin
                r = v;
            end else begin
                r = (v * m_act[ch] + (longint'(1) << (GF - 1))) >> GF;
                if (r > 255) begin
                    r = 255;
                    any_sat = 1;
                end
            end
            e.d[ch*PW +: PW] = PW'(r);
        end
        e.sat = de && any_sat && !m_byp;
        return e;
    endfunction

    task automatic model_reset();
        m_pend = 0;
        m_byp  = 0;
        for (int ch = 0; ch < CH; ch++) m_act[ch] = longint'(1) << GF;
    endtask

    // Runs right after the active edge, seeing the same inputs the DUT sampled
    task automatic model_update();
        int n;
        n = hist.size();
        m_rst_edge = rst;
        if (rst) begin
            hist.push_back(zero_e());
            if (n >= 1) hist[n-1] = zero_e();
            if (n >= 2) hist[n-2] = zero_e();
            model_reset();
        end else begin
            hist.push_back(model_pixel(di_i, de_i, hs_i, vs_i));
            if (gain_wr_i) begin
                for (int ch = 0; ch < CH; ch++) m_pend_g[ch] = longint'(gain_i[ch*GW +: GW]);
                m_pend = 1;
            end else if (vs_i && m_pend) begin
                for (int ch = 0; ch < CH; ch++) m_act[ch] = m_pend_g[ch];
                m_pend = 0;
            end
            if (vs_i) m_byp = bypass_i;
        end
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, hist.size(), got, exp);
        end
    endtask

    task automatic compare();
        int     idx;
        exp_t   e;
        longint inc;
        idx = hist.size() - 3;
        e = (idx >= 0) ? hist[idx] : zero_e();
        if (m_rst_edge) begin
            m_cnt = 0; m_count = 0; m_prev_vs = 0;
        end else begin
            inc = m_cnt;
            if (prev_e.de && prev_e.sat && m_cnt < (longint'(1) << SW) - 1) inc = m_cnt + 1;
            if (prev_e.vs && !m_prev_vs) begin
                m_count = inc;
                m_cnt   = 0;
            end else begin
                m_cnt = inc;
            end
            m_prev_vs = prev_e.vs;
        end
        check("do_o", 64'(do_o), 64'(e.d));
        check("syncs", 64'({de_o, hs_o, vs_o}), 64'({e.de, e.hs, e.vs}));
        check("sat_o", 64'(sat_o), 64'(e.sat));
        check("sat_count_o", 64'(sat_count_o), 64'(m_count));
        prev_e = e;
    endtask

    task automatic step(input logic [CH*PW-1:0] pix, input bit de, input bit hs, input bit vs);
        di_i = pix; de_i = de; hs_i = hs; vs_i = vs;
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
        gain_wr_i = 0;
    endtask

    task automatic idle();
        step('0, 0, 0, 0);
    endtask

    task automatic blank(input int k);
        repeat (k) step('0, 0, 0, 1);
    endtask

    task automatic write_gain(input int g2, input int g1, input int g0);
        gain_i    = {GW'(g2), GW'(g1), GW'(g0)};
        gain_wr_i = 1;
    endtask

    // mode 0: flat value v on all channels; mode 1: position-dependent ramp
    task automatic frame(input int w, input int h, input int mode, input int v, input int per);
        logic [CH*PW-1:0] p;
        bit de;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (mode == 0) p = {3{PW'(v)}};
                else           p = {PW'(y*53 + x), PW'(x*11 + v), PW'(x*37 + y*3)};
                de = (per == 0) ? 1'b1 : ((x % per) == 0);
                step(p, de, 0, 0);
            end
            step('0, 0, 1, 0);
            step('0, 0, 1, 0);
        end
    endtask

    initial begin
        rst = 1; gain_i = '0; gain_wr_i = 0; bypass_i = 0;
        di_i = '0; de_i = 0; hs_i = 0; vs_i = 1;
        prev_e = zero_e(); m_cnt = 0; m_count = 0; m_prev_vs = 0; m_rst_edge = 0;
        for (int ch = 0; ch < CH; ch++) m_pend_g[ch] = 0;
        model_reset();

        blank(3);
        check("reset_do", 64'(do_o), 64'h0);
        check("reset_syncs", 64'({de_o, hs_o, vs_o, sat_o}), 64'h0);
        check("reset_count", 64'(sat_count_o), 64'h0);
        rst = 0;

        // Unity gain: pass-through, 255 does not clip
        blank(3);
        frame(8, 4, 1, 5, 0);
        step(24'hFFFFFF, 1, 0, 0); idle(); idle();
        check("unity_255", 64'({do_o, sat_o}), {24'hFFFFFF, 1'b0});
        blank(4);
        check("unity_count", 64'(sat_count_o), 64'd0);

        // Gain 6253 (~6.1064)
        write_gain(6253, 6253, 6253);
        blank(3);
        step(24'hFDFDFD, 1, 0, 0); step(24'h141414, 1, 0, 0); idle();
        check("g6253_253", 64'({do_o, sat_o}), {24'hFFFFFF, 1'b1});
        idle();
        check("g6253_20", 64'({do_o, sat_o}), {24'h7A7A7A, 1'b0});
        blank(4);
        check("probe_count", 64'(sat_count_o), 64'd1);
        frame(25, 25, 0, 253, 0);
        blank(4);
        check("count_625", 64'(sat_count_o), 64'd625);

        // Gain 0.5 rounding and independent channel gains
        write_gain(512, 512, 512);
        blank(3);
        step(24'h030303, 1, 0, 0); step(24'h010101, 1, 0, 0); step(24'h000000, 1, 0, 0);
        check("half_3", 64'(do_o), 64'h020202);
        idle();
        check("half_1", 64'(do_o), 64'h010101);
        idle();
        check("half_0", 64'(do_o), 64'h000000);
        write_gain(2048, 1024, 512);
        blank(3);
        step(24'h646464, 1, 0, 0); idle(); idle();
        check("per_channel", 64'(do_o), 64'hC86432);
        frame(12, 3, 1, 9, 4);

        // Mid-frame write: held until vertical blanking
        step(24'h123456, 1, 0, 0);
        write_gain(2048, 2048, 2048);
        step(24'h646464, 1, 0, 0); idle(); idle();
        check("midframe_old", 64'(do_o), 64'hC86432);
        blank(3);
        step(24'h646464, 1, 0, 0); idle(); idle();
        check("nextframe_x2", 64'(do_o), 64'hC8C8C8);
        frame(6, 2, 1, 0, 2);
        write_gain(1024, 1024, 1024);
        step(24'h222222, 1, 0, 0);
        write_gain(3072, 3072, 3072);
        blank(1);
        step(24'h282828, 1, 0, 0); idle(); idle();
        check("wr_beats_apply", 64'(do_o), 64'h505050);
        blank(2);
        step(24'h282828, 1, 0, 0); idle(); idle();
        check("late_apply_x3", 64'(do_o), 64'h787878);

        // Bypass is frame-synchronous
        write_gain(6253, 6253, 6253);
        blank(3);
        step(24'h101010, 1, 0, 0);
        bypass_i = 1;
        step(24'hFDFDFD, 1, 0, 0); idle(); idle();
        check("byp_midframe", 64'({do_o, sat_o}), {24'hFFFFFF, 1'b1});
        blank(4);
        check("byp_prev_count", 64'(sat_count_o), 64'd1);
        frame(10, 3, 0, 253, 0);
        step(24'hFDFDFD, 1, 0, 0); idle(); idle();
        check("byp_pass", 64'({do_o, sat_o}), {24'hFDFDFD, 1'b0});
        bypass_i = 0;
        frame(5, 1, 1, 7, 0);
        blank(4);
        check("byp_count", 64'(sat_count_o), 64'd0);

        // Reset mid-line with DE every other cycle
        frame(4, 2, 0, 253, 2);
        blank(4);
        check("pre_rst_count", 64'(sat_count_o), 64'd4);
        step(24'hFDFDFD, 1, 0, 0); step('0, 0, 0, 0);
        write_gain(2048, 2048, 2048);
        step(24'hFDFDFD, 1, 0, 0); step('0, 0, 0, 0);
        rst = 1;
        step(24'hFDFDFD, 1, 0, 0);
        check("rst_do", 64'(do_o), 64'h0);
        check("rst_syncs", 64'({de_o, hs_o, vs_o, sat_o}), 64'h0);
        check("rst_count", 64'(sat_count_o), 64'h0);
        rst = 0;
        frame(6, 2, 1, 3, 2);
        blank(4);
        step(24'h646464, 1, 0, 0); idle(); idle();
        check("post_rst_unity", 64'(do_o), 64'h646464);
        blank(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_gain.md
# pixel_gain

Multi-channel per-pixel digital gain stage for the video pipeline, placed after the scalers (scaler_h/scaler_v) on the same di/de/hs/vs stream. Each channel is multiplied by an unsigned fixed-point gain, rounded half-up and saturated to the pixel range. Gain and bypass changes take effect only during vertical blanking, so a frame never mixes two gains. A per-frame saturation counter reports clipping for auto-exposure firmware.

## Interface
- CHANNEL_COUNT, 3: channels per pixel; channel n occupies `di_i[n*PIXEL_WIDTH +: PIXEL_WIDTH]` (0=B, 1=G, 2=R).
- PIXEL_WIDTH, 8: bits per channel; 4..16.
- GAIN_WIDTH, 16: unsigned gain width per channel.
- GAIN_FRAC, 10: fractional gain bits; 1.0 = 1<<GAIN_FRAC; 1..GAIN_WIDTH-1.
- SAT_CNT_WIDTH, 24: saturation counter width.

- clk  in  1  pixel clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- gain_i  in  CHANNEL_COUNT*GAIN_WIDTH  new gains; channel n at `[n*GAIN_WIDTH +: GAIN_WIDTH]`.
- gain_wr_i  in  1  one-cycle strobe; captures gain_i into the pending register.
- bypass_i  in  1  1 = pass pixels unmodified; frame-synchronous.
- di_i  in  CHANNEL_COUNT*PIXEL_WIDTH  input pixel.
- de_i, hs_i, vs_i  in  1 each  data enable; line blank (high between lines); frame blank (high between frames).
- do_o  out  CHANNEL_COUNT*PIXEL_WIDTH  gained pixel.
- de_o, hs_o, vs_o  out  1 each  de_i/hs_i/vs_i delayed to align with do_o.
- sat_o  out  1  high with de_o when any channel of that pixel saturated.
- sat_count_o  out  SAT_CNT_WIDTH  saturated-pixel count of the last completed frame.

## Operation
- Registers: pending gains plus a pend flag; active gains plus an active bypass flag.
- gain_wr_i=1: pending <= gain_i and pend <= 1. A later write before apply overwrites pending.
- Apply: on a cycle with vs_i=1 and pend=1 and gain_wr_i=0, active <= pending and pend <= 0. If gain_wr_i=1 in the same cycle, the write takes precedence. Apply then happens on the next vs_i=1 cycle.
- Every cycle with vs_i=1, the active bypass flag <= bypass_i. While vs_i=0 it is frozen.
- Per channel, with full-width intermediates and no truncation before saturation:
  - p = pix * gain, width PIXEL_WIDTH+GAIN_WIDTH.
  - s = p + (1<<(GAIN_FRAC-1)).
  - r = s >> GAIN_FRAC.
  - out = (r > 2^PIXEL_WIDTH-1) ? 2^PIXEL_WIDTH-1 : r.
  - The channel is flagged saturated when r exceeds the max.
- Gain 0 yields 0.
- Bypass: do_o equals di_i delayed by the pipeline latency; sat_o=0; the counter does not increment.
- Pixel arithmetic is computed regardless of de_i. sat_o is qualified by de_o.
- Counter: sat_cnt increments on each de_o&sat_o and sticks at its all-ones maximum.
  - On the rising edge of vs_o (vs_o=1, previous vs_o=0): sat_count_o <= sat_cnt (including a hit in that same cycle) and sat_cnt <= 0.

## Timing
- Three-stage pipeline:
  - S1 registers di and syncs and selects active gain/bypass.
  - S2 multiplies.
  - S3 rounds, saturates and registers outputs.
- Latency is 3 clk for do_o, de_o, hs_o, vs_o and sat_o. Throughput is one pixel per clock, with any de_i duty cycle (DE_I_PERIOD 0/2/4 patterns).
- The gain used for a pixel is the active gain at the cycle that pixel enters S1.
- A gain applied in cycle t affects inputs from t+1; its first outputs appear at t+4.
- Reset values:
  - do_o=0, de_o=0, hs_o=0, vs_o=0, sat_o=0, sat_count_o=0.
  - Pipeline cleared.
  - pend=0, active gains = 1<<GAIN_FRAC for all channels, active bypass = 0.
- Reset mid-frame drops all in-flight pixels. Outputs reach reset values on the cycle after rst is sampled high. Nothing is flushed.
- vs_i held high from reset: a pending gain is applied one cycle after the write.

## Test plan
- Reset, then stream one frame with default gains: do_o == di_i delayed 3 clk. For pixel 255, sat_o=0 and sat_count_o=0 at the end of the frame.
- Write gain 6253 (6.1064 in Q.10) to all channels during vs_i=1:
  - pixel 253 -> 255 with sat_o=1.
  - pixel 20 -> 122 (125572>>10).
  - For a 25x25 frame of 253, the next vs_o rise gives sat_count_o=625.
- Gain 512 (0.5): pixel 3 -> 2 (round half-up); pixel 1 -> 1; pixel 0 -> 0. Channels use independent gains (B=512, G=1024, R=2048): input 100/100/100 -> 50/100/200.
- Mid-frame update: write gain 2048 while vs_i=0. The rest of the current frame still uses the old gain. The first pixel of the next frame is doubled. A second write in the same cycle as the apply condition -> the second value is applied one cycle later.
- Bypass asserted mid-frame: no effect until vs_i=1. In the next frame, do_o == di_i (delay 3) with gain 6253 active, sat_o=0 and sat_count_o=0.
- rst pulsed mid-line with DE_I_PERIOD=2: outputs zero on the cycle after rst is sampled high. Active gain returns to 1.0 and a pending write is discarded. The next frame passes through unchanged.
